// File: rtl/dnn_ctrl_pkg.sv
// Shared types and sizing constants for the fix6 MNIST engine and its batch controller.
package dnn_ctrl_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_WIDTH  = 6;
    localparam int IDX_WIDTH   = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        SCAN  = 3'd4,
        EMIT  = 3'd5,
        NEXT  = 3'd6
    } state_t;

endpackage

// File: rtl/dnn_argmax_acc.sv
// Running argmax over a stream of signed values; strict-greater compare keeps the
// lowest index on ties.
module dnn_argmax_acc #(
    parameter int DATA_WIDTH = dnn_ctrl_pkg::DATA_WIDTH,
    parameter int IDX_WIDTH  = dnn_ctrl_pkg::IDX_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] value,
    input  logic        [IDX_WIDTH-1:0]  idx,
    output logic signed [DATA_WIDTH-1:0] best_val,
    output logic        [IDX_WIDTH-1:0]  best_idx
);
    import dnn_ctrl_pkg::*;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_val <= '0;
            best_idx <= '0;
        end else if (load) begin
            best_val <= value;
            best_idx <= idx;
        end else if (en && (value > best_val)) begin
            best_val <= value;
            best_idx <= idx;
        end
    end

endmodule

// File: rtl/dnn_batch_ctrl.sv
// Batch sequencer: per image clears/starts the engine, waits for done, scans the
// class outputs into a running argmax and emits one result over valid/ready.
module dnn_batch_ctrl #(
    parameter int DATA_WIDTH     = dnn_ctrl_pkg::DATA_WIDTH,
    parameter int NUM_CLASSES    = dnn_ctrl_pkg::NUM_CLASSES,
    parameter int IDX_WIDTH      = dnn_ctrl_pkg::IDX_WIDTH,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic        [CNT_WIDTH-1:0]  req_count,
    output logic                         eng_reset,
    output logic                         eng_start,
    input  logic                         eng_done,
    output logic        [IDX_WIDTH-1:0]  eng_out_idx,
    input  logic signed [DATA_WIDTH-1:0] eng_out,
    output logic        [CNT_WIDTH-1:0]  img_idx,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic        [IDX_WIDTH-1:0]  res_class,
    output logic signed [DATA_WIDTH-1:0] res_score,
    output logic        [CNT_WIDTH-1:0]  res_img,
    output logic                         busy,
    output logic                         batch_done,
    output logic                         timeout_err
);
    import dnn_ctrl_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   count_reg;
    logic [CNT_WIDTH-1:0]   img_idx_reg;
    logic [IDX_WIDTH-1:0]   scan_idx_reg;
    logic [WD_W-1:0]        wdog_reg;
    logic                   timeout_err_reg;
    logic                   batch_done_reg;

    logic scan_last, wd_expired, last_img;

    assign scan_last  = (scan_idx_reg == IDX_WIDTH'(NUM_CLASSES - 1));
    assign wd_expired = (wdog_reg == WD_W'(TIMEOUT_CYCLES));
    assign last_img   = (img_idx_reg == (count_reg - CNT_WIDTH'(1)));

    always_comb begin
        state_next  = state_reg;
        req_ready   = 1'b0;
        eng_reset   = 1'b0;
        eng_start   = 1'b0;
        eng_out_idx = '0;
        res_valid   = 1'b0;
        busy        = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && (req_count != '0))
                    state_next = CLR;
            end
            CLR: begin
                eng_reset  = 1'b1;
                state_next = START;
            end
            START: begin
                eng_start  = 1'b1;
                state_next = WAIT;
            end
            // done takes priority over an expiring watchdog in the same cycle
            WAIT: begin
                if (eng_done)
                    state_next = SCAN;
                else if (wd_expired)
                    state_next = IDLE;
            end
            SCAN: begin
                eng_out_idx = scan_idx_reg;
                if (scan_last)
                    state_next = EMIT;
            end
            EMIT: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_next = NEXT;
            end
            NEXT: begin
                state_next = last_img ? IDLE : CLR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            img_idx_reg     <= '0;
            scan_idx_reg    <= '0;
            wdog_reg        <= '0;
            timeout_err_reg <= 1'b0;
            batch_done_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            batch_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        count_reg       <= req_count;
                        img_idx_reg     <= '0;
                        timeout_err_reg <= 1'b0;
                        if (req_count == '0)
                            batch_done_reg <= 1'b1;
                    end
                end
                START: wdog_reg <= '0;
                WAIT: begin
                    if (!eng_done) begin
                        if (wd_expired) begin
                            timeout_err_reg <= 1'b1;
                            batch_done_reg  <= 1'b1;
                        end else begin
                            wdog_reg <= wdog_reg + WD_W'(1);
                        end
                    end
                end
                SCAN: scan_idx_reg <= scan_last ? '0 : scan_idx_reg + IDX_WIDTH'(1);
                NEXT: begin
                    if (last_img)
                        batch_done_reg <= 1'b1;
                    else
                        img_idx_reg <= img_idx_reg + CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Accumulator only moves during SCAN, so the result fields stay frozen through EMIT.
    dnn_argmax_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .load     ((state_reg == SCAN) && (scan_idx_reg == '0)),
        .en       (state_reg == SCAN),
        .value    (eng_out),
        .idx      (scan_idx_reg),
        .best_val (res_score),
        .best_idx (res_class)
    );

    assign img_idx     = img_idx_reg;
    assign res_img     = img_idx_reg;
    assign batch_done  = batch_done_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_dnn_batch_ctrl.sv
// Directed bench for dnn_batch_ctrl with a behavioural engine model driving done and class outputs.
module tb_dnn_batch_ctrl;

    localparam int DW = 6;
    localparam int NC = 10;
    localparam int IW = 4;
    localparam int CW = 8;
    localparam int TO = 100;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic [CW-1:0]        req_count;
    logic                 eng_reset;
    logic                 eng_start;
    logic                 eng_done = 1'b0;
    logic [IW-1:0]        eng_out_idx;
    logic signed [DW-1:0] eng_out;
    logic [CW-1:0]        img_idx;
    logic                 res_valid;
    logic                 res_ready;
    logic [IW-1:0]        res_class;
    logic signed [DW-1:0] res_score;
    logic [CW-1:0]        res_img;
    logic                 busy;
    logic                 batch_done;
    logic                 timeout_err;

    int total = 0;
    int bad   = 0;

    // engine model state
    logic signed [DW-1:0] vals_mem [0:39];
    int  done_delay = 50;
    bit  done_en    = 1'b1;
    bit  model_clr  = 1'b0;
    int  start_cnt  = 0;
    int  reset_cnt  = 0;
    int  eng_img    = 0;
    int  run_cnt    = 0;
    bit  running    = 1'b0;

    localparam logic [36:0] RESET_VEC = {1'b1, 36'b0};

    always #5 clk = ~clk;

    dnn_batch_ctrl #(
        .DATA_WIDTH     (DW),
        .NUM_CLASSES    (NC),
        .IDX_WIDTH      (IW),
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_count   (req_count),
        .eng_reset   (eng_reset),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .eng_out_idx (eng_out_idx),
        .eng_out     (eng_out),
        .img_idx     (img_idx),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_class   (res_class),
        .res_score   (res_score),
        .res_img     (res_img),
        .busy        (busy),
        .batch_done  (batch_done),
        .timeout_err (timeout_err)
    );

    assign eng_out = vals_mem[eng_img * NC + int'(eng_out_idx)];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_done <= 1'b0;
            running  <= 1'b0;
        end else begin
            if (model_clr) begin
                start_cnt <= 0;
                reset_cnt <= 0;
            end
            if (eng_reset) begin
                eng_done <= 1'b0;
                running  <= 1'b0;
                if (!model_clr) reset_cnt <= reset_cnt + 1;
            end
            if (eng_start) begin
                running <= done_en;
                run_cnt <= 1;
                eng_img <= start_cnt % 4;
                if (!model_clr) start_cnt <= start_cnt + 1;
            end else if (running) begin
                run_cnt <= run_cnt + 1;
                if (run_cnt + 1 >= done_delay) begin
                    eng_done <= 1'b1;
                    running  <= 1'b0;
                end
            end
        end
    end

    function automatic logic [36:0] out_vec();
        return {req_ready, busy, eng_reset, eng_start, eng_out_idx, img_idx, res_valid,
                res_class, res_score, res_img, batch_done, timeout_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        model_clr = 1'b1;
        tick();
        model_clr = 1'b0;
    endtask

    task automatic set_img(input int img, input int v [10]);
        for (int i = 0; i < NC; i++) begin
            vals_mem[img * NC + i] = v[i][DW-1:0];
        end
    endtask

    task automatic send_req(input int n);
        req_count = n[CW-1:0];
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_res(input int budget, output bit got);
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        got = (res_valid === 1'b1);
    endtask

    task automatic wait_batch(input int budget, output bit got);
        int n;
        n = 0;
        while (batch_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        got = (batch_done === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_count = '0; res_ready = 1'b0;
        repeat (3) tick();
        total++;
        if (out_vec() !== RESET_VEC) begin
            bad++;
            $display("FAIL reset_in_rst: got %h want %h", out_vec(), RESET_VEC);
        end
        rst = 1'b0;
        tick();
        total++;
        if (out_vec() !== RESET_VEC) begin
            bad++;
            $display("FAIL reset_after_rst: got %h want %h", out_vec(), RESET_VEC);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int  n;
        bit  scan_ok;
        set_img(0, '{-3, 5, 2, 5, 1, 0, -1, 4, 3, -32});
        done_en = 1'b1; done_delay = 50; res_ready = 1'b0;
        clear_model();
        send_req(1);
        n = 0;
        while (eng_done !== 1'b1 && n < 200) begin tick(); n++; end
        total++;
        if (eng_done !== 1'b1) begin
            bad++;
            $display("FAIL single_engine_done: got %b want 1", eng_done);
        end
        n = 0; scan_ok = 1'b1;
        while (res_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n <= 10 && eng_out_idx !== IW'(n - 1)) scan_ok = 1'b0;
        end
        total++;
        if (n != 11) begin
            bad++;
            $display("FAIL single_latency: got %0d want 11", n);
        end
        total++;
        if (!scan_ok) begin
            bad++;
            $display("FAIL single_scan_idx_seq: got out-of-order index want 0..9");
        end
        total++;
        if (res_class !== 4'd1 || res_score !== 6'sd5 || res_img !== 8'd0) begin
            bad++;
            $display("FAIL single_result: got c=%0d s=%0d i=%0d want c=1 s=5 i=0",
                     res_class, res_score, res_img);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || batch_done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_next_state: got v=%b bd=%b busy=%b want 0 0 1",
                     res_valid, batch_done, busy);
        end
        tick();
        total++;
        if (batch_done !== 1'b1 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_batch_done: got bd=%b rdy=%b want 1 1", batch_done, req_ready);
        end
        tick();
        total++;
        if (batch_done !== 1'b0) begin
            bad++;
            $display("FAIL single_batch_done_pulse: got %b want 0", batch_done);
        end
        $display("test_single done");
    endtask

    task automatic test_three();
        logic [IW-1:0]        rc [8];
        logic signed [DW-1:0] rs [8];
        logic [CW-1:0]        ri [8];
        int exp_cls [3] = '{7, 0, 9};
        int exp_sc  [3] = '{20, 10, 31};
        int nres, n;
        set_img(0, '{0, 0, 0, 19, 0, 0, 0, 20, -4, 0});
        set_img(1, '{10, -5, -5, -5, -5, 10, -5, -5, -5, -5});
        set_img(2, '{30, 30, 30, 30, 30, 30, 30, 30, 30, 31});
        done_en = 1'b1; done_delay = 5; res_ready = 1'b1;
        clear_model();
        send_req(3);
        nres = 0; n = 0;
        while (batch_done !== 1'b1 && n < 500) begin
            if (res_valid === 1'b1 && nres < 8) begin
                rc[nres] = res_class; rs[nres] = res_score; ri[nres] = res_img;
                nres++;
            end
            tick();
            n++;
        end
        total++;
        if (batch_done !== 1'b1 || nres != 3) begin
            bad++;
            $display("FAIL three_count: got bd=%b results=%0d want bd=1 results=3", batch_done, nres);
        end
        for (int i = 0; i < 3 && i < nres; i++) begin
            total++;
            if (rc[i] !== IW'(exp_cls[i]) || rs[i] !== DW'(exp_sc[i]) || ri[i] !== CW'(i)) begin
                bad++;
                $display("FAIL three_result%0d: got c=%0d s=%0d i=%0d want c=%0d s=%0d i=%0d",
                         i, rc[i], rs[i], ri[i], exp_cls[i], exp_sc[i], i);
            end
        end
        total++;
        if (reset_cnt != 3 || start_cnt != 3) begin
            bad++;
            $display("FAIL three_pulses: got resets=%0d starts=%0d want 3 3", reset_cnt, start_cnt);
        end
        res_ready = 1'b0;
        tick();
        $display("test_three done");
    endtask

    task automatic test_ties();
        bit got;
        set_img(0, '{-32, -32, -32, -32, -32, -32, -32, -32, -32, -32});
        done_en = 1'b1; done_delay = 3; res_ready = 1'b1;
        clear_model();
        send_req(1);
        wait_res(200, got);
        total++;
        if (!got || res_class !== 4'd0 || res_score !== -6'sd32) begin
            bad++;
            $display("FAIL ties_all_min: got v=%b c=%0d s=%0d want v=1 c=0 s=-32",
                     got, res_class, res_score);
        end
        wait_batch(20, got);
        res_ready = 1'b0;
        tick();
        $display("test_ties done");
    endtask

    task automatic test_hold();
        bit got, hold_ok;
        int nres;
        set_img(0, '{1, 2, 3, 4, 5, 6, 7, 8, 9, -1});
        set_img(1, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        done_en = 1'b1; done_delay = 4; res_ready = 1'b0;
        clear_model();
        send_req(2);
        wait_res(200, got);
        total++;
        if (!got) begin
            bad++;
            $display("FAIL hold_first_valid: got %b want 1", res_valid);
        end
        hold_ok = 1'b1;
        repeat (20) begin
            tick();
            if (res_valid !== 1'b1 || res_class !== 4'd8 || res_score !== 6'sd9 ||
                res_img !== 8'd0 || eng_start !== 1'b0) hold_ok = 1'b0;
        end
        total++;
        if (!hold_ok || start_cnt != 1) begin
            bad++;
            $display("FAIL hold_stable: got ok=%b starts=%0d c=%0d s=%0d want ok=1 starts=1 c=8 s=9",
                     hold_ok, start_cnt, res_class, res_score);
        end
        res_ready = 1'b1;
        tick();
        nres = 0; got = 1'b0;
        for (int n = 0; n < 300 && batch_done !== 1'b1; n++) begin
            if (res_valid === 1'b1) begin
                nres++;
                got = (res_img === 8'd1 && res_class === 4'd0 && res_score === 6'sd0);
            end
            tick();
        end
        total++;
        if (nres != 1 || !got || batch_done !== 1'b1) begin
            bad++;
            $display("FAIL hold_second_result: got results=%0d match=%b bd=%b want 1 1 1",
                     nres, got, batch_done);
        end
        res_ready = 1'b0;
        tick();
        $display("test_hold done");
    endtask

    task automatic test_timeout();
        bit saw_valid, got;
        done_en = 1'b0; res_ready = 1'b1;
        clear_model();
        send_req(1);
        saw_valid = 1'b0;
        repeat (90) begin
            tick();
            if (res_valid === 1'b1) saw_valid = 1'b1;
        end
        total++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: got err=%b busy=%b want 0 1", timeout_err, busy);
        end
        got = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (res_valid === 1'b1) saw_valid = 1'b1;
            if (batch_done === 1'b1) begin got = 1'b1; break; end
            tick();
        end
        total++;
        if (!got || timeout_err !== 1'b1 || req_ready !== 1'b1 || saw_valid) begin
            bad++;
            $display("FAIL timeout_abort: got bd=%b err=%b rdy=%b saw_valid=%b want 1 1 1 0",
                     got, timeout_err, req_ready, saw_valid);
        end
        send_req(0);
        total++;
        if (timeout_err !== 1'b0 || batch_done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL count0_clear: got err=%b bd=%b busy=%b want 0 1 0",
                     timeout_err, batch_done, busy);
        end
        tick();
        total++;
        if (batch_done !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL count0_pulse: got bd=%b rdy=%b want 0 1", batch_done, req_ready);
        end
        done_en = 1'b1; res_ready = 1'b0;
        $display("test_timeout done");
    endtask

    task automatic test_rst_mid();
        bit got;
        int n;
        set_img(0, '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        set_img(1, '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0});
        set_img(2, '{0, 0, 3, 0, 0, 0, 0, 0, 0, 0});
        set_img(3, '{0, 0, 0, 4, 0, 0, 0, 0, 0, 0});
        done_en = 1'b1; done_delay = 4; res_ready = 1'b1;
        clear_model();
        send_req(4);
        n = 0;
        while (!(start_cnt == 2 && eng_out_idx === 4'd4) && n < 500) begin tick(); n++; end
        total++;
        if (start_cnt != 2 || eng_out_idx !== 4'd4 || img_idx !== 8'd1) begin
            bad++;
            $display("FAIL rst_mid_reach_scan: got starts=%0d idx=%0d img=%0d want 2 4 1",
                     start_cnt, eng_out_idx, img_idx);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (out_vec() !== RESET_VEC) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %h want %h", out_vec(), RESET_VEC);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (batch_done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_idle: got bd=%b rdy=%b busy=%b want 0 1 0",
                     batch_done, req_ready, busy);
        end
        set_img(0, '{0, 0, 0, 7, 0, 0, 0, 0, 0, 0});
        clear_model();
        send_req(1);
        wait_res(200, got);
        total++;
        if (!got || res_class !== 4'd3 || res_score !== 6'sd7 || res_img !== 8'd0) begin
            bad++;
            $display("FAIL rst_mid_rerun: got v=%b c=%0d s=%0d i=%0d want 1 3 7 0",
                     got, res_class, res_score, res_img);
        end
        wait_batch(20, got);
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rst_mid_rerun_done: got %b want 1", batch_done);
        end
        res_ready = 1'b0;
        tick();
        $display("test_rst_mid done");
    endtask

    initial begin
        for (int i = 0; i < 40; i++) vals_mem[i] = '0;
        test_reset();
        test_single();
        test_three();
        test_ties();
        test_hold();
        test_timeout();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
